// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mips_pkg                                                     |
// | Description : Shared MIPS32 definitions for the fetch path: opcode set,    |
// |               instruction field layout, fetch FSM encoding and the queue   |
// |               entry type.                                                  |
// | Contents    : opcode_t, instr_t, fetch_state_t, fq_entry_t, is_hlt()       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mips_pkg;

  // Opcode set of the simple MIPS32 subset executed by this pipeline.
  typedef enum logic [5:0] {
    OP_ALU   = 6'b000000,
    OP_LW    = 6'b001000,
    OP_SW    = 6'b001001,
    OP_ADDI  = 6'b001010,
    OP_SUBI  = 6'b001011,
    OP_SLTI  = 6'b001100,
    OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110,
    OP_HLT   = 6'b111111
  } opcode_t;

  // Field layout of an instruction word, MSB first: opcode[31:26],
  // rs[25:21], rt[20:16], immediate / rd+shamt+funct[15:0].
  typedef struct packed {
    opcode_t     opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } instr_t;

  // Fetch FSM encoding.
  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_WAIT    = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_t;

  // One queue entry: instruction word and the address following it.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } fq_entry_t;

  function automatic logic is_hlt(input logic [31:0] word);
    instr_t f;
    f = instr_t'(word);
    return f.opcode == OP_HLT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_fetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : mips_fetch_queue_if                                          |
// | Description : Bundles the instruction-memory request/response channel, the |
// |               decode-side valid/ready channel and the redirect/halt        |
// |               controls of the fetch queue.                                 |
// | Modports    : master - the fetch queue (drives imem_req/addr, fq_*)        |
// |               slave  - the environment (memory, decode, branch unit)       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mips_fetch_queue_if #(
  parameter int AW = 10
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          fq_valid;
  logic [31:0]   fq_ir;
  logic [31:0]   fq_npc;
  logic          fq_ready;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          halt;

  modport master (
    output imem_req, imem_addr, fq_valid, fq_ir, fq_npc,
    input  imem_rvalid, imem_rdata, fq_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, fq_valid, fq_ir, fq_npc,
    output imem_rvalid, imem_rdata, fq_ready, redirect, redirect_pc, halt
  );
endinterface
`default_nettype wire

// File: rtl/mips_fq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_fq_fifo                                                 |
// | Description : Synchronous DEPTH x 64 FIFO of {ir, npc} entries with push,  |
// |               pop, flush and occupancy count. The head entry is read       |
// |               straight from the storage registers.                        |
// | Ports       : clk1, rst       - clock, synchronous active-high reset       |
// |               push, push_data - write an entry at the tail                 |
// |               pop             - drop the head entry (ignored when empty)   |
// |               flush           - empty the FIFO                             |
// |               head, count     - head entry and occupancy                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mips_fq_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic                     push,
  input  fq_entry_t                push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fq_entry_t                head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  fq_entry_t      mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    cnt;
  logic           pop_ok;

  assign pop_ok = pop && (cnt != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
endmodule
`default_nettype wire

// File: rtl/mips_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_fetch_queue                                             |
// | Description : Instruction prefetch queue in front of the IF/ID boundary.   |
// |               Owns the fetch PC, issues single-outstanding word reads,     |
// |               buffers {ir, npc} entries and flushes on a taken branch.     |
// |               Fetching stops once an HLT instruction has been queued.      |
// | Ports       : clk1, rst - clock, synchronous active-high reset             |
// |               bus       - mips_fetch_queue_if.master (imem request and     |
// |                           response, fq_valid/ready/ir/npc, redirect,       |
// |                           redirect_pc, halt)                               |
// | Config      : MIPS_FQ_BYPASS_EN - when defined, a response arriving at an  |
// |               empty queue is presented on fq_* in the same cycle.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mips_fetch_queue
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 10,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                clk1,
  input  logic                rst,
  mips_fetch_queue_if.master  bus
);
  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t   state;
  logic [31:0]    pc;
  logic [31:0]    req_pc;
  logic           hlt_seen;

  logic [CW-1:0]  count;
  fq_entry_t      head;
  fq_entry_t      push_data;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;
  logic           issue;
  logic           resp_ok;
  logic           bypass;

  // The outstanding read already owns a slot: issuing only from IDLE with
  // count < DEPTH guarantees the response always has room.
  assign issue      = !rst && (state == FS_IDLE) && !bus.halt && !hlt_seen
                      && !bus.redirect && (count < FULL);
  assign resp_ok    = (state == FS_WAIT) && bus.imem_rvalid && !bus.redirect;
  assign fifo_empty = (count == '0);
  assign push_data  = '{ir: bus.imem_rdata, npc: req_pc + 32'd1};

`ifdef MIPS_FQ_BYPASS_EN
  assign bypass = resp_ok && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed response consumed in the same cycle never enters the FIFO.
  assign fifo_push = resp_ok && !(bypass && bus.fq_ready);
  assign fifo_pop  = !fifo_empty && bus.fq_ready && !bus.redirect;

  mips_fq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk1      (clk1),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .flush     (bus.redirect),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_req  = issue;
  assign bus.imem_addr = issue ? pc[AW-1:0] : '0;
  assign bus.fq_valid  = bypass || !fifo_empty;
  assign bus.fq_ir     = bypass ? push_data.ir  : head.ir;
  assign bus.fq_npc    = bypass ? push_data.npc : head.npc;

  always_ff @(posedge clk1) begin
    if (rst) begin
      state    <= FS_IDLE;
      pc       <= RESET_PC;
      req_pc   <= '0;
      hlt_seen <= 1'b0;
    end else begin
      if (bus.redirect) begin
        pc       <= bus.redirect_pc;
        hlt_seen <= 1'b0;
      end else if (issue) begin
        pc <= pc + 32'd1;
      end

      if (issue) req_pc <= pc;

      // resp_ok excludes redirect, so this never fights the clear above.
      if (resp_ok && is_hlt(bus.imem_rdata)) hlt_seen <= 1'b1;

      case (state)
        FS_IDLE:    if (issue) state <= FS_WAIT;
        FS_WAIT: begin
          // A response coinciding with a redirect is simply dropped.
          if (bus.imem_rvalid)   state <= FS_IDLE;
          else if (bus.redirect) state <= FS_DISCARD;
        end
        FS_DISCARD: if (bus.imem_rvalid) state <= FS_IDLE;
        default:    state <= FS_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mips_fetch_queue                                          |
// | Description : Self-checking bench for mips_fetch_queue. A memory model     |
// |               answers reads after a programmable latency; the expected     |
// |               instruction stream (from the fetch start address up to and   |
// |               including the first HLT) is queued on every reset/redirect   |
// |               and a negedge monitor pops and compares every consumed entry |
// |               and every issued read address.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mips_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam int          AW       = 10;
  localparam int          MEMW     = 1 << AW;
  localparam logic [31:0] RESET_PC = 32'd5;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;

  mips_fetch_queue_if #(.AW(AW)) bus ();

  mips_fetch_queue #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  initial forever #5 clk1 = ~clk1;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mem [MEMW];
  int          lat = 2;
  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] exp_req_pc;
  bit          req_stopped;
  int          req_cnt = 0;
  int          hs_cnt = 0;
  logic [31:0] last_npc;
  logic [AW-1:0] last_req_addr;
  bit          req_pend = 0;
  logic [AW-1:0] req_pend_addr;
  bit          prev_hold = 0;
  logic [63:0] prev_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit word_is_hlt(input logic [31:0] w);
    return w[31:26] == 6'b111111;
  endfunction

  // Expected stream from a fetch start address: sequential words up to and
  // including the first HLT.
  function automatic void refill(input logic [31:0] start);
    logic [31:0] p;
    p = start;
    sb.delete();
    for (int i = 0; i < 600; i++) begin
      sb.push_back('{ir: mem[p[AW-1:0]], npc: p + 32'd1});
      if (word_is_hlt(mem[p[AW-1:0]])) break;
      p = p + 32'd1;
    end
  endfunction

  // Monitor / scoreboard.
  always @(negedge clk1) begin
    if (rst) begin
      refill(RESET_PC);
      exp_req_pc  = RESET_PC;
      req_stopped = 0;
      prev_hold   = 0;
      req_pend    = 0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(bus.fq_valid), 64'd1);
        check("hold_data", {bus.fq_ir, bus.fq_npc}, prev_data);
      end
      if (bus.fq_valid && bus.fq_ready && !bus.redirect) begin
        hs_cnt++;
        last_npc = bus.fq_npc;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL entry: got ir=%h npc=%h, required no entry", bus.fq_ir, bus.fq_npc);
        end else begin
          mon_e = sb.pop_front();
          check("entry", {bus.fq_ir, bus.fq_npc}, mon_e);
        end
      end
      if (bus.imem_req) begin
        req_cnt++;
        last_req_addr = bus.imem_addr;
        check("req_gate", {61'd0, bus.redirect, bus.halt, req_stopped}, 64'd0);
        check("req_addr", 64'(bus.imem_addr), 64'(exp_req_pc[AW-1:0]));
        if (word_is_hlt(mem[exp_req_pc[AW-1:0]])) req_stopped = 1;
        exp_req_pc = exp_req_pc + 32'd1;
      end
      if (bus.redirect) begin
        refill(bus.redirect_pc);
        exp_req_pc  = bus.redirect_pc;
        req_stopped = 0;
      end
      req_pend      = bus.imem_req;
      req_pend_addr = bus.imem_addr;
      prev_hold     = bus.fq_valid && !bus.fq_ready && !bus.redirect;
      prev_data     = {bus.fq_ir, bus.fq_npc};
    end
  end

  // Instruction memory: one outstanding read, answered after lat cycles.
  initial begin
    int cnt;
    logic [AW-1:0] a;
    cnt = 0;
    a = '0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    forever begin
      @(posedge clk1);
      #2;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      if (rst) begin
        cnt = 0;
      end else begin
        if (req_pend) begin
          cnt = lat;
          a   = req_pend_addr;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem[a];
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic sample();
    @(negedge clk1);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    bus.redirect    = 1'b1;
    bus.redirect_pc = target;
    step();
    bus.redirect    = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int r0, h0;
    bit got;

    for (int i = 0; i < MEMW; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b111111) w[31] = 1'b0;
      mem[i] = w;
    end
    mem[0]   = 32'h2801000A;
    mem[1]   = 32'h28020014;
    mem[2]   = 32'h00221800;
    mem[3]   = 32'hFC000000;
    mem[700] = 32'hFC000000;

    rst = 1'b1;
    bus.fq_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.halt = 1'b0;
    lat = 2;

    // Reset state.
    repeat (3) @(posedge clk1);
    sample();
    check("rst_req",   64'(bus.imem_req),  64'd0);
    check("rst_addr",  64'(bus.imem_addr), 64'd0);
    check("rst_valid", 64'(bus.fq_valid),  64'd0);
    check("rst_ir",    64'(bus.fq_ir),     64'd0);
    check("rst_npc",   64'(bus.fq_npc),    64'd0);
    step();
    rst = 1'b0;
    sample();
    check("first_req",  64'(bus.imem_req),  64'd1);
    check("first_addr", 64'(bus.imem_addr), 64'(RESET_PC[AW-1:0]));

    // Short program ending in HLT at word 3.
    step();
    bus.fq_ready = 1'b1;
    repeat (6) step();
    redirect_to(32'd0);
    sample();
    h0 = hs_cnt;
    repeat (40) step();
    sample();
    check("prog_count", 64'(hs_cnt - h0), 64'd4);
    check("prog_drained", 64'(sb.size()), 64'd0);
    check("prog_last_npc", 64'(last_npc), 64'd4);
    r0 = req_cnt;
    repeat (20) step();
    sample();
    check("hlt_no_req", 64'(req_cnt - r0), 64'd0);

    // Backpressure fills exactly DEPTH entries.
    step();
    bus.fq_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd100;
    sample();
    r0 = req_cnt;
    step();
    bus.redirect = 1'b0;
    repeat (20) step();
    sample();
    check("bp_reqs", 64'(req_cnt - r0), 64'(DEPTH));
    check("bp_req_idle", 64'(bus.imem_req), 64'd0);
    check("bp_head", {bus.fq_ir, bus.fq_npc}, {mem[100], 32'd101});
    step();
    bus.fq_ready = 1'b1;
    h0 = hs_cnt;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      sample();
      if (hs_cnt - h0 >= DEPTH + 3) got = 1;
    end
    check("bp_drain_resume", 64'(got), 64'd1);

    // Redirect while a read is outstanding; stale data arrives 2 cycles later.
    step();
    lat = 3;
    redirect_to(32'd200);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      sample();
      if (bus.imem_req) got = 1;
    end
    check("wait_req_200", 64'(got), 64'd1);
    step();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd40;
    sample();
    r0 = req_cnt;
    h0 = hs_cnt;
    step();
    bus.redirect = 1'b0;
    sample();
    check("valid_after_redirect", 64'(bus.fq_valid), 64'd0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (req_cnt > r0) got = 1;
      else sample();
    end
    check("redir_req_seen", 64'(got), 64'd1);
    check("redir_addr", 64'(last_req_addr), 64'd40);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (hs_cnt > h0) got = 1;
      else sample();
    end
    check("redir_out_seen", 64'(got), 64'd1);
    check("redir_first_npc", 64'(last_npc), 64'd41);

    // Response latency into an empty queue.
    step();
    lat = 2;
    redirect_to(32'd300);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      sample();
      if (bus.imem_req && bus.imem_addr == 10'd300) got = 1;
    end
    check("lat_req_seen", 64'(got), 64'd1);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      sample();
      if (bus.imem_rvalid) got = 1;
    end
    check("lat_rvalid_seen", 64'(got), 64'd1);
`ifdef MIPS_FQ_BYPASS_EN
    check("bypass_valid", 64'(bus.fq_valid), 64'd1);
    check("bypass_ir", 64'(bus.fq_ir), 64'(mem[300]));
`else
    check("nobypass_valid0", 64'(bus.fq_valid), 64'd0);
    sample();
    check("nobypass_valid1", 64'(bus.fq_valid), 64'd1);
    check("nobypass_ir", 64'(bus.fq_ir), 64'(mem[300]));
`endif

    // Halt blocks new requests.
    step();
    bus.halt = 1'b1;
    repeat (6) step();
    sample();
    r0 = req_cnt;
    repeat (10) step();
    sample();
    check("halt_no_req", 64'(req_cnt - r0), 64'd0);
    step();
    bus.halt = 1'b0;

    // 32-bit wrap of pc/npc.
    redirect_to(32'hFFFF_FFFE);
    h0 = hs_cnt;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      sample();
      if (hs_cnt - h0 >= 3) got = 1;
    end
    check("wrap_progress", 64'(got), 64'd1);

    // Randomised traffic.
    step();
    for (int i = 0; i < 3000; i++) begin
      bus.fq_ready    = ($urandom % 10) < 7;
      bus.halt        = ($urandom % 20) == 0;
      lat             = 1 + int'($urandom % 4);
      bus.redirect    = ($urandom % 50) == 0;
      bus.redirect_pc = (($urandom % 8) == 0) ? ($urandom % 4) : ($urandom % MEMW);
      step();
    end
    bus.halt = 1'b0;
    bus.redirect = 1'b0;
    repeat (10) step();

    // Reset dominates a simultaneous redirect.
    rst = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'd77;
    repeat (2) step();
    rst = 1'b0;
    bus.redirect = 1'b0;
    sample();
    check("rst_dom_req",  64'(bus.imem_req),  64'd1);
    check("rst_dom_addr", 64'(bus.imem_addr), 64'(RESET_PC[AW-1:0]));
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/mips_fetch_queue.md
# mips_fetch_queue

Instruction prefetch queue sitting directly upstream of the MIPS32 IF/ID boundary. It owns the fetch PC, issues word reads to instruction memory over a request/response interface, and buffers returned instructions with their NPC in a small FIFO. The decode side consumes entries through a valid/ready handshake. A taken-branch redirect from the EX/MEM side flushes the queue and discards any in-flight read.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2
- AW, 10: instruction-memory word-address width (1024 words)
- RESET_PC, 32'd0: fetch PC after reset
- clk1  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  one-cycle read request pulse
- imem_addr  out  AW  word address, equal to pc[AW-1:0]; valid only when imem_req=1
- imem_rvalid  in  1  read data valid; ≥1 cycle after imem_req; at most one outstanding read
- imem_rdata  in  32  instruction word
- fq_valid  out  1  head entry valid
- fq_ir  out  32  head instruction
- fq_npc  out  32  head instruction address + 1
- fq_ready  in  1  consumer accepts head this cycle
- redirect  in  1  taken branch; flush and refetch
- redirect_pc  in  32  new fetch PC
- halt  in  1  level; blocks new requests while high

## Operation
- Registers: pc (32b), req_pc (32b, address of outstanding read), FIFO of {ir, npc}, count (log2(DEPTH)+1 bits), hlt_seen.
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE -> WAIT: issue when !halt && !hlt_seen && !redirect && count < DEPTH; imem_req=1, req_pc<=pc, pc<=pc+1.
  - WAIT, imem_rvalid: push {imem_rdata, req_pc+1}; -> IDLE. Push never overflows: issue reserved the slot.
  - WAIT, redirect without rvalid -> DISCARD.
  - WAIT, redirect with rvalid in same cycle: response dropped; -> IDLE.
  - DISCARD, imem_rvalid: drop data; -> IDLE. Redirect in DISCARD only updates pc.
- Redirect (any state): count<=0, pc<=redirect_pc, hlt_seen<=0; a pop in the same cycle is ignored; no issue that cycle.
- Pop when fq_valid && fq_ready. A push and a pop in the same cycle leave count unchanged.
- HLT stop: when a pushed ir[31:26]==HLT, set hlt_seen and issue no further requests until redirect or rst.
- Arithmetic: pc and npc wrap modulo 2^32. imem_addr truncates to AW bits.
- Issue condition includes the slot occupied by the outstanding read, so count + inflight ≤ DEPTH always.

## Timing
- Reset: imem_req=0, imem_addr=0, fq_valid=0, fq_ir=0, fq_npc=0, state=IDLE, count=0, pc=RESET_PC, hlt_seen=0.
- rst dominates redirect and all other inputs. Instruction memory shares rst; rvalid is never asserted for a pre-reset request.
- First imem_req: first cycle after rst deasserts.
- Response-to-fq_valid latency: 1 cycle (registered FIFO output).
- Sustained throughput with read latency L: one instruction per L+1 cycles.
- fq_ir/fq_npc hold while fq_valid && !fq_ready.
- fq_valid=0 in the cycle after redirect.

## Configuration
- MIPS_FQ_BYPASS_EN defined: if the FIFO is empty and the response is not dropped, imem_rdata drives fq_ir/fq_npc combinationally with fq_valid=1 in the rvalid cycle. If fq_ready is also high, the entry is consumed without a push (0-cycle latency). The HLT check still applies.
- Undefined: all outputs are registered; latency is as in Timing.

## Structure
- mips_pkg: opcode parameters (HLT=6'b111111 and the rest of the ISA set), fetch FSM state encoding, shared instruction-field slice positions.
- Sub-module mips_fq_fifo: synchronous DEPTH×64 FIFO with push/pop/flush, count, and registered head output. The FSM and pc logic stay in mips_fetch_queue.

## Test plan
- Reset with RESET_PC=5: all outputs 0. First cycle after reset: imem_req=1, imem_addr=5.
- Memory latency 2, fq_ready=1, words 0..2 = 32'h2801000A, 32'h28020014, 32'h00221800 -> emitted in order with npc 1, 2, 3.
- fq_ready=0 for 20 cycles -> exactly DEPTH entries buffered, then imem_req stays 0. Raise fq_ready -> all entries drain in order and fetching resumes.
- Redirect to 40 while in WAIT; the stale rvalid arrives 2 cycles later -> stale data dropped, next imem_addr=40, first emitted npc=41.
- Word 3 = 32'hFC000000 (HLT) -> no imem_req after its response. Redirect to 0 -> fetching resumes at 0.
- With MIPS_FQ_BYPASS_EN, empty queue, fq_ready=1 -> fq_valid and fq_ir valid in the rvalid cycle. Without it -> one cycle later.
